uart_packet_framer: RTL and testbench
=====================================

// Module: uart_packet_framer
// PURPOSE
//  Downstream of the register read responder. Collects one UART_PACKET byte stream (SoP..EoP),
//  buffers the payload, then frames it as SYNC, DEST, SRC, LENGTH, payload bytes for the UART
//  byte transmitter. Paces upstream with a ready level whose 1->0 transition means "byte taken".
// PARAMETERS
//  SYNC_BYTE   8'h55  first byte of every frame
//  MAX_LENGTH  16     payload buffer depth in bytes (1..255)
// PORTS
//  ipClk        in   1      system clock
//  ipReset      in   1      reset: asynchronous, active-high
//  ipTxStream   in   UART_PACKET  {Source,Destination,Length,SoP,EoP,Valid,Data}; byte when Valid=1
//  opTxReady    in->out 1   high = can accept a byte; drops low for 1 cycle after each accept
//  opUartData   out  8      byte to UART transmitter
//  opUartSend   out  1      one-cycle pulse: opUartData valid, start transmission
//  ipUartBusy   in   1      high while UART transmitter shifts a byte
//  opOverflow   out  1      sticky: payload bytes dropped in current packet
//  opBusy       out  1      high from first accepted byte until last frame byte handed off
// BEHAVIOUR
//  Reset (async, ipReset=1): state=IDLE, opTxReady=0, opUartSend=0, opUartData=0, opOverflow=0,
//   opBusy=0, byte count=0, read pointer=0. First cycle after release: opTxReady=1.
//  States: IDLE, COLLECT, SEND_HDR, SEND_DATA, WAIT_UART.
//  IDLE: opTxReady=1. Valid&SoP -> latch Source, Destination; store Data at addr 0; count=1;
//   opOverflow=0; opTxReady=0 for 1 cycle; ->COLLECT (or ->SEND_HDR if EoP same beat).
//   Valid without SoP: byte discarded, still acknowledged by 1-cycle opTxReady drop.
//  COLLECT: each Valid beat while opTxReady=1 stores Data at addr=count, count+1, ready dropped 1 cycle.
//   Valid while opTxReady=0: ignored (not stored, no ack). count==MAX_LENGTH: byte dropped,
//   opOverflow=1, still acked. EoP beat (stored or dropped) -> SEND_HDR, opTxReady=0.
//   SoP in COLLECT: restart packet (header relatched, count=1, opOverflow=0).
//  ipTxStream.Length is informational only; transmitted LENGTH = bytes actually stored (8-bit).
//  SEND_HDR: emits SYNC_BYTE, Destination, Source, count in that order; SEND_DATA: buffer[0..count-1].
//  UART handshake per byte: when ipUartBusy=0, drive opUartData and pulse opUartSend 1 cycle,
//   ->WAIT_UART; wait for ipUartBusy=1 then ipUartBusy=0 (min 1 cycle each), return to
//   next byte. Never pulse opUartSend while ipUartBusy=1.
//  After last payload byte completes: ->IDLE, opBusy=0, opTxReady=1 next cycle. Payload count 0
//   impossible (SoP always stores). Frame latency: first opUartSend 1 cycle after EoP accept
//   when ipUartBusy=0.
//  opTxReady=0 throughout SEND_HDR/SEND_DATA/WAIT_UART; upstream stalls naturally.
//  Reset mid-frame: frame abandoned immediately, no further opUartSend; buffer contents don't care.
//  Pointers/counters 8-bit, no wrap: count saturates at MAX_LENGTH.
// STRUCTURE
//  Structures package: add FRAMER_STATE enum typedef and UART_SYNC_BYTE localparam default;
//   UART_PACKET reused unchanged.
//  Sub-module: framer_payload_buffer (MAX_LENGTH x 8 register file, 1 write port,
//   1 sync-read port, read data valid 1 cycle after address); FSM and handshake in top.
// TESTING
//  1) SoP D=0x00 S=0x01 then bytes 0xDE,0xAD,0xBE,0xEF(EoP), UART model busy 10 cycles ->
//     UART sees 55 00 01 04 DE AD BE EF, one send pulse per byte, opOverflow=0.
//  2) MAX_LENGTH=4, send 6 payload bytes, EoP on 6th -> LENGTH=04, first 4 bytes only,
//     opOverflow=1 until next SoP; all 6 bytes acked via opTxReady drop.
//  3) Single-byte packet SoP&EoP Data=0x7A -> 55 D S 01 7A; opBusy low after last byte done.
//  4) Hold ipUartBusy=1 for 50 cycles before first byte -> no opUartSend until busy falls;
//     never a send while busy high (assertion).
//  5) Assert ipReset during payload byte 2 of frame -> outputs at reset values same edge
//     (async); after release new packet frames correctly from SYNC.
//  6) Valid bytes without SoP in IDLE (0x11,0x22) then normal packet -> stray bytes absent
//     from UART output; SoP inside COLLECT restarts packet with new header.

Source files
------------

// File: rtl/uart_packet_framer_pkg.sv
// Shared types for the UART packet framer.
//   UART_PACKET    : upstream byte-stream beat (header fields plus one data byte)
//   FRAMER_STATE   : framer FSM encoding, also exported on the debug port
//   UART_SYNC_BYTE : default first byte of every transmitted frame
package uart_packet_framer_pkg;

  localparam logic [7:0] UART_SYNC_BYTE = 8'h55;

  typedef struct packed {
    logic [7:0] Source;
    logic [7:0] Destination;
    logic [7:0] Length;
    logic       SoP;
    logic       EoP;
    logic       Valid;
    logic [7:0] Data;
  } UART_PACKET;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    COLLECT   = 3'd1,
    SEND_HDR  = 3'd2,
    SEND_DATA = 3'd3,
    WAIT_UART = 3'd4
  } FRAMER_STATE;

endpackage

// File: rtl/uart_packet_framer_if.sv
// Bus bundle between the packet source, the framer and the UART transmitter.
//   ipTxStream : packet beats from upstream (a byte is offered when Valid=1)
//   opTxReady  : framer ready level
//   opUartData : byte for the UART transmitter
//   opUartSend : one-cycle start pulse for opUartData
//   ipUartBusy : UART transmitter shifting a byte
//   opOverflow : sticky, payload bytes were dropped in the current packet
//   opBusy     : framer holds a packet (collecting or transmitting)
//
// Handshake: a beat is taken on a rising clock edge where Valid=1 and opTxReady=1.
// The framer then drops opTxReady for at least one cycle; that 1->0 transition is
// the acknowledge, and the source may present its next beat. A Valid beat seen
// while opTxReady=0 is ignored. On the UART side, opUartSend is only pulsed when
// ipUartBusy=0, and the framer then waits for ipUartBusy to rise and fall again.
interface uart_packet_framer_if;
  import uart_packet_framer_pkg::*;

  UART_PACKET ipTxStream;
  logic       opTxReady;
  logic [7:0] opUartData;
  logic       opUartSend;
  logic       ipUartBusy;
  logic       opOverflow;
  logic       opBusy;

  // Upstream source and UART transmitter side
  modport master (
    output ipTxStream,
    output ipUartBusy,
    input  opTxReady,
    input  opUartData,
    input  opUartSend,
    input  opOverflow,
    input  opBusy
  );

  // Framer side
  modport slave (
    input  ipTxStream,
    input  ipUartBusy,
    output opTxReady,
    output opUartData,
    output opUartSend,
    output opOverflow,
    output opBusy
  );

endinterface

// File: rtl/framer_payload_buffer.sv
// Payload store for the framer: DEPTH x 8 register file, one write port and one
// synchronous read port (rd_data reflects rd_addr one clock later).
//   clk     : clock
//   wr_en   : write strobe
//   wr_addr : write address (writes at or beyond DEPTH are discarded)
//   wr_data : write data
//   rd_addr : read address
//   rd_data : registered read data
// Contents are not reset; they are always written before being read.
module framer_payload_buffer #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       wr_en,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [7:0] rd_addr,
  output logic [7:0] rd_data
);

  localparam int         AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [7:0] DEPTH_LIM = 8'(DEPTH);

  logic [7:0] mem [2**AW];
  logic [7:0] rd_data_d;
  logic [7:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en && (wr_addr < DEPTH_LIM)) begin
      mem[wr_addr[AW-1:0]] <= wr_data;
    end
  end

  always_comb begin
    rd_data_d = 8'h00;
    if (rd_addr < DEPTH_LIM) begin
      rd_data_d = mem[rd_addr[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/uart_packet_framer.sv
// UART packet framer: collects one packet (SoP..EoP) from the byte stream,
// buffers its payload, then sends SYNC, DEST, SRC, LENGTH, payload to the UART
// byte transmitter, one byte per UART busy cycle.
//   ipClk      : clock
//   ipReset    : asynchronous active-high reset
//   bus        : stream / UART bundle (slave side), see uart_packet_framer_if
//   opDbgState : current FSM state for observation
module uart_packet_framer
  import uart_packet_framer_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE  = UART_SYNC_BYTE,
  parameter int         MAX_LENGTH = 16
) (
  input  logic                 ipClk,
  input  logic                 ipReset,
  uart_packet_framer_if.slave  bus,
  output FRAMER_STATE          opDbgState
);

  localparam logic [7:0] MAX_COUNT = 8'(MAX_LENGTH);

  FRAMER_STATE state_q, state_d;
  logic        tx_ready_q, tx_ready_d;
  logic [7:0]  uart_data_q, uart_data_d;
  logic        uart_send_q, uart_send_d;
  logic        overflow_q, overflow_d;
  logic [7:0]  count_q, count_d;
  logic [7:0]  rd_ptr_q, rd_ptr_d;
  logic [2:0]  hdr_idx_q, hdr_idx_d;
  logic        seen_busy_q, seen_busy_d;
  logic [7:0]  src_q, src_d;
  logic [7:0]  dst_q, dst_d;

  UART_PACKET  pkt;
  logic        accept;
  logic        start_pkt;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [7:0]  rd_data;
  logic [7:0]  hdr_byte;
  logic        unused_length;

  assign pkt = bus.ipTxStream;
  // Length is informational only; the frame carries the stored byte count.
  assign unused_length = ^pkt.Length;

  // tx_ready_q is only ever set in IDLE/COLLECT, the state test keeps it explicit.
  assign accept    = pkt.Valid && tx_ready_q &&
                     ((state_q == IDLE) || (state_q == COLLECT));
  assign start_pkt = accept && pkt.SoP;

  always_comb begin
    hdr_byte = count_q;
    case (hdr_idx_q[1:0])
      2'd0:    hdr_byte = SYNC_BYTE;
      2'd1:    hdr_byte = dst_q;
      2'd2:    hdr_byte = src_q;
      default: hdr_byte = count_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    tx_ready_d  = 1'b0;
    uart_data_d = uart_data_q;
    uart_send_d = 1'b0;
    overflow_d  = overflow_q;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    hdr_idx_d   = hdr_idx_q;
    seen_busy_d = seen_busy_q;
    src_d       = src_q;
    dst_d       = dst_q;
    wr_en       = 1'b0;
    wr_addr     = count_q;

    // Payload capture, shared by IDLE and COLLECT. SoP always (re)starts a packet.
    if (start_pkt) begin
      wr_en      = 1'b1;
      wr_addr    = 8'd0;
      count_d    = 8'd1;
      overflow_d = 1'b0;
      src_d      = pkt.Source;
      dst_d      = pkt.Destination;
      rd_ptr_d   = 8'd0;
      hdr_idx_d  = 3'd0;
    end else if (accept && (state_q == COLLECT)) begin
      if (count_q < MAX_COUNT) begin
        wr_en   = 1'b1;
        wr_addr = count_q;
        count_d = count_q + 8'd1;
      end else begin
        overflow_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        // Stray beats without SoP are acked but change nothing else.
        tx_ready_d = !accept;
        if (start_pkt) begin
          state_d = pkt.EoP ? SEND_HDR : COLLECT;
        end
      end

      COLLECT: begin
        tx_ready_d = !accept;
        if (accept && pkt.EoP) begin
          state_d    = SEND_HDR;
          tx_ready_d = 1'b0;
        end
      end

      SEND_HDR: begin
        if (!bus.ipUartBusy) begin
          uart_data_d = hdr_byte;
          uart_send_d = 1'b1;
          hdr_idx_d   = hdr_idx_q + 3'd1;
          seen_busy_d = 1'b0;
          state_d     = WAIT_UART;
        end
      end

      SEND_DATA: begin
        // rd_ptr_q has been stable through the preceding WAIT_UART, so the
        // registered read data already matches it.
        if (!bus.ipUartBusy) begin
          uart_data_d = rd_data;
          uart_send_d = 1'b1;
          rd_ptr_d    = rd_ptr_q + 8'd1;
          seen_busy_d = 1'b0;
          state_d     = WAIT_UART;
        end
      end

      WAIT_UART: begin
        // Byte is done only after busy has been seen high and then low.
        if (!seen_busy_q) begin
          if (bus.ipUartBusy) begin
            seen_busy_d = 1'b1;
          end
        end else if (!bus.ipUartBusy) begin
          seen_busy_d = 1'b0;
          if (hdr_idx_q != 3'd4) begin
            state_d = SEND_HDR;
          end else if (rd_ptr_q == count_q) begin
            state_d   = IDLE;
            rd_ptr_d  = 8'd0;
            hdr_idx_d = 3'd0;
          end else begin
            state_d = SEND_DATA;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge ipClk or posedge ipReset) begin
    if (ipReset) begin
      state_q     <= IDLE;
      tx_ready_q  <= 1'b0;
      uart_data_q <= 8'h00;
      uart_send_q <= 1'b0;
      overflow_q  <= 1'b0;
      count_q     <= 8'd0;
      rd_ptr_q    <= 8'd0;
      hdr_idx_q   <= 3'd0;
      seen_busy_q <= 1'b0;
      src_q       <= 8'h00;
      dst_q       <= 8'h00;
    end else begin
      state_q     <= state_d;
      tx_ready_q  <= tx_ready_d;
      uart_data_q <= uart_data_d;
      uart_send_q <= uart_send_d;
      overflow_q  <= overflow_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      hdr_idx_q   <= hdr_idx_d;
      seen_busy_q <= seen_busy_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
    end
  end

  framer_payload_buffer #(
    .DEPTH (MAX_LENGTH)
  ) u_payload_buffer (
    .clk     (ipClk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (pkt.Data),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_data)
  );

  assign bus.opTxReady  = tx_ready_q;
  assign bus.opUartData = uart_data_q;
  assign bus.opUartSend = uart_send_q;
  assign bus.opOverflow = overflow_q;
  assign bus.opBusy     = (state_q != IDLE);
  assign opDbgState     = state_q;

endmodule

// File: tb/tb_uart_packet_framer.sv
// Bench for uart_packet_framer: directed scenarios followed by random packets.
// Expected UART bytes come from a packet-level reference model that pushes whole
// frames into exp_q; a monitor pops and compares on every send pulse.
module tb_uart_packet_framer;
  import uart_packet_framer_pkg::*;

  localparam int MAX_LEN = 4;
  localparam int BUDGET  = 4000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_packet_framer_if u_if();
  FRAMER_STATE dbg_state;

  uart_packet_framer #(
    .SYNC_BYTE  (8'h55),
    .MAX_LENGTH (MAX_LEN)
  ) dut (
    .ipClk      (clk),
    .ipReset    (rst),
    .bus        (u_if.slave),
    .opDbgState (dbg_state)
  );

  logic model_busy = 1'b0;
  logic hold_busy  = 1'b0;
  bit   rand_busy  = 1'b0;
  assign u_if.ipUartBusy = model_busy | hold_busy;

  int total = 0;
  int bad   = 0;
  int sends_seen = 0;
  logic [7:0] exp_q[$];

  // ---------------- reference model (packet level) ----------------
  bit         m_active = 1'b0;
  bit         m_ovf    = 1'b0;
  logic [7:0] m_src, m_dst;
  logic [7:0] m_payload[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Returns 1 when this beat completes a frame.
  task automatic model_beat(input bit sop, input bit eop, input logic [7:0] s,
                            input logic [7:0] d, input logic [7:0] data, output bit frame_out);
    frame_out = 1'b0;
    if (sop) begin
      m_active  = 1'b1;
      m_src     = s;
      m_dst     = d;
      m_payload = {data};
      m_ovf     = 1'b0;
    end else if (m_active) begin
      if (m_payload.size() < MAX_LEN) m_payload.push_back(data);
      else m_ovf = 1'b1;
    end
    if (m_active && eop) begin
      exp_q.push_back(8'h55);
      exp_q.push_back(m_dst);
      exp_q.push_back(m_src);
      exp_q.push_back(8'(m_payload.size()));
      foreach (m_payload[i]) exp_q.push_back(m_payload[i]);
      m_active  = 1'b0;
      frame_out = 1'b1;
    end
  endtask

  // ---------------- driver tasks (called on a negedge) ----------------
  task automatic send_byte(input bit sop, input bit eop, input logic [7:0] s,
                           input logic [7:0] d, input logic [7:0] data);
    int waited = 0;
    bit fo;
    u_if.ipTxStream = '{Source: s, Destination: d, Length: 8'($urandom),
                        SoP: sop, EoP: eop, Valid: 1'b1, Data: data};
    while (u_if.opTxReady !== 1'b1 && waited < BUDGET) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= BUDGET) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got no ready expected ready within %0d cycles", BUDGET);
      u_if.ipTxStream.Valid = 1'b0;
      return;
    end
    @(negedge clk);
    u_if.ipTxStream.Valid = 1'b0;
    check("ack_drop", u_if.opTxReady, 1'b0);
    model_beat(sop, eop, s, d, data, fo);
    check("overflow", u_if.opOverflow, m_ovf);
    check("busy_level", u_if.opBusy, m_active | fo);
  endtask

  task automatic send_packet(input logic [7:0] s, input logic [7:0] d, input int n,
                             input bit restart_mid);
    logic [7:0] cs = s;
    logic [7:0] cd = d;
    for (int i = 0; i < n; i++) begin
      bit sop = (i == 0);
      if (restart_mid && n > 2 && i == n / 2) begin
        sop = 1'b1;
        cs  = s ^ 8'h80;
        cd  = d ^ 8'h0F;
      end
      send_byte(sop, (i == n - 1), cs, cd, 8'($urandom));
    end
  endtask

  task automatic wait_drain(input string name);
    int waited = 0;
    while ((exp_q.size() != 0 || u_if.opBusy !== 1'b0) && waited < BUDGET) begin
      @(negedge clk);
      waited++;
    end
    check({name, "_exp_left"}, exp_q.size(), 0);
    check({name, "_busy_done"}, u_if.opBusy, 1'b0);
    @(negedge clk);
    check({name, "_ready_back"}, u_if.opTxReady, 1'b1);
  endtask

  // ---------------- UART transmitter model ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (u_if.opUartSend === 1'b1 && !rst) begin
        int n = rand_busy ? $urandom_range(1, 12) : 10;
        @(negedge clk);
        model_busy = 1'b1;
        repeat (n) @(negedge clk);
        model_busy = 1'b0;
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (u_if.opUartSend === 1'b1 && !rst) begin
        sends_seen++;
        check("send_while_busy", u_if.ipUartBusy, 1'b0);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_send: got %0h expected no send", u_if.opUartData);
        end else begin
          check("uart_byte", u_if.opUartData, exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #900000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    int base;
    int waited;
    u_if.ipTxStream = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready", u_if.opTxReady, 1'b0);
    check("rst_send", u_if.opUartSend, 1'b0);
    check("rst_data", u_if.opUartData, 8'h00);
    check("rst_ovf", u_if.opOverflow, 1'b0);
    check("rst_busy", u_if.opBusy, 1'b0);
    check("rst_state", dbg_state, IDLE);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", u_if.opTxReady, 1'b1);

    // 1) four-byte packet
    base = sends_seen;
    send_byte(1'b1, 1'b0, 8'h01, 8'h00, 8'hDE);
    check("t1_state_collect", dbg_state, COLLECT);
    send_byte(1'b0, 1'b0, 8'h01, 8'h00, 8'hAD);
    send_byte(1'b0, 1'b0, 8'h01, 8'h00, 8'hBE);
    send_byte(1'b0, 1'b1, 8'h01, 8'h00, 8'hEF);
    wait_drain("t1");
    check("t1_send_count", sends_seen - base, 8);
    check("t1_ovf", u_if.opOverflow, 1'b0);

    // 2) six bytes into a four-byte buffer
    send_packet(8'h12, 8'h34, 6, 1'b0);
    wait_drain("t2");
    check("t2_ovf_sticky", u_if.opOverflow, 1'b1);

    // 3) single-byte packet; SoP clears the sticky overflow
    base = sends_seen;
    send_byte(1'b1, 1'b1, 8'h44, 8'h33, 8'h7A);
    wait_drain("t3");
    check("t3_send_count", sends_seen - base, 5);

    // 4) UART held busy before the first byte
    hold_busy = 1'b1;
    base = sends_seen;
    send_packet(8'h5A, 8'hA5, 2, 1'b0);
    repeat (50) @(negedge clk);
    check("t4_no_send_while_held", sends_seen - base, 0);
    check("t4_state_hdr", dbg_state, SEND_HDR);
    hold_busy = 1'b0;
    wait_drain("t4");
    check("t4_send_count", sends_seen - base, 6);

    // 5) reset while payload byte 2 is in the UART
    base = sends_seen;
    send_packet(8'h21, 8'h43, 4, 1'b0);
    waited = 0;
    while (sends_seen - base < 6 && waited < BUDGET) begin
      @(negedge clk);
      waited++;
    end
    check("t5_reached_byte2", sends_seen - base, 6);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("t5_rst_send", u_if.opUartSend, 1'b0);
    check("t5_rst_data", u_if.opUartData, 8'h00);
    check("t5_rst_ready", u_if.opTxReady, 1'b0);
    check("t5_rst_busy", u_if.opBusy, 1'b0);
    check("t5_rst_state", dbg_state, IDLE);
    exp_q.delete();
    m_active = 1'b0;
    m_ovf    = 1'b0;
    base = sends_seen;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("t5_no_send_after_rst", sends_seen - base, 0);
    send_packet(8'h66, 8'h77, 3, 1'b0);
    wait_drain("t5");
    check("t5_new_frame_count", sends_seen - base, 7);

    // 6) stray bytes in IDLE, then a packet restarted by a second SoP
    base = sends_seen;
    send_byte(1'b0, 1'b0, 8'h00, 8'h00, 8'h11);
    send_byte(1'b0, 1'b0, 8'h00, 8'h00, 8'h22);
    check("t6_stray_idle", dbg_state, IDLE);
    send_packet(8'h0A, 8'h0B, 5, 1'b1);
    wait_drain("t6");
    check("t6_send_count", sends_seen - base, 7);

    // Random packets with random UART busy lengths
    rand_busy = 1'b1;
    for (int p = 0; p < 20; p++) begin
      if ($urandom_range(0, 4) == 0) send_byte(1'b0, 1'($urandom_range(0, 1)), 8'h00, 8'h00, 8'($urandom));
      send_packet(8'($urandom), 8'($urandom), $urandom_range(1, 6), ($urandom_range(0, 5) == 0));
    end
    wait_drain("rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
